// File: rtl/gate_vector_player.sv
// Replays a programmed table of {a,b,c,d} vectors onto the gate block, holds each for
// hold+1 cycles, captures the response, checks it against the table, and streams it out.
module gate_vector_player #(
    parameter int NUM_VEC = 5,
    parameter int HOLD_W  = 4,
    parameter int OUT_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tbl_wr_en,
    input  logic [$clog2(NUM_VEC)-1:0] tbl_wr_addr,
    input  logic [3:0]                 tbl_wr_vec,
    input  logic [HOLD_W-1:0]          tbl_wr_hold,
    input  logic [OUT_W-1:0]           tbl_wr_exp,
    input  logic                       start,
    output logic [3:0]                 abcd,
    input  logic [OUT_W-1:0]           dut_resp,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [OUT_W+3:0]           resp_data,
    output logic                       resp_match,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 err_count
);

    localparam int ADDR_W = $clog2(NUM_VEC);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    logic [3:0]        vec_q  [NUM_VEC];
    logic [HOLD_W-1:0] hold_q [NUM_VEC];
    logic [OUT_W-1:0]  exp_q  [NUM_VEC];

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [3:0]        abcd_q;
    logic              resp_valid_q;
    logic [OUT_W+3:0]  resp_data_q;
    logic              resp_match_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        err_q;

    logic              wr_ok;
    logic              wr_addr0;
    logic [3:0]        vec0_d;
    logic [HOLD_W-1:0] hold0_d;
    logic [ADDR_W-1:0] idx_d;
    logic              match_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A write landing on entry 0 in the same cycle as start must be seen by the run.
    always_comb begin
        wr_ok    = tbl_wr_en && (state_q == IDLE) && (int'(tbl_wr_addr) < NUM_VEC);
        wr_addr0 = wr_ok && (tbl_wr_addr == '0);
        vec0_d   = wr_addr0 ? tbl_wr_vec  : vec_q[0];
        hold0_d  = wr_addr0 ? tbl_wr_hold : hold_q[0];
        idx_d    = idx_q + 1'b1;
        match_d  = (dut_resp == exp_q[idx_q]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                vec_q[i]  <= '0;
                hold_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else if (wr_ok) begin
            vec_q[tbl_wr_addr]  <= tbl_wr_vec;
            hold_q[tbl_wr_addr] <= tbl_wr_hold;
            exp_q[tbl_wr_addr]  <= tbl_wr_exp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            abcd_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_match_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DRIVE;
                        idx_q   <= '0;
                        err_q   <= '0;
                        cnt_q   <= hold0_d;
                        abcd_q  <= vec0_d;
                        busy_q  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        resp_data_q  <= {vec_q[idx_q], dut_resp};
                        resp_match_q <= match_d;
                        if (!match_d) begin
                            err_q <= sat_inc(err_q);
                        end
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    // abcd stays on the current vector until the consumer takes the beat.
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            abcd_q  <= '0;
                        end else begin
                            idx_q   <= idx_d;
                            cnt_q   <= hold_q[idx_d];
                            abcd_q  <= vec_q[idx_d];
                            state_q <= DRIVE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign abcd       = abcd_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_match = resp_match_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_gate_vector_player.sv
// Directed bench for gate_vector_player: a behavioural gate block answers abcd, and each
// run is checked beat by beat against hand-computed responses.
module tb_gate_vector_player;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        tbl_wr_en;
    logic [2:0]  tbl_wr_addr;
    logic [3:0]  tbl_wr_vec;
    logic [3:0]  tbl_wr_hold;
    logic [9:0]  tbl_wr_exp;
    logic        start;
    logic [3:0]  abcd;
    logic [9:0]  dut_resp;
    logic        resp_valid;
    logic        resp_ready;
    logic [13:0] resp_data;
    logic        resp_match;
    logic        busy;
    logic        done;
    logic [7:0]  err_count;

    logic        start_b;
    logic [3:0]  abcd_b;
    logic        valid_b;
    logic [13:0] data_b;
    logic        match_b;
    logic        busy_b;
    logic        done_b;
    logic [7:0]  err_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_vec  [5];
    logic [3:0] m_hold [5];
    logic [9:0] m_exp  [5];
    logic [9:0] m_resp [5];

    gate_vector_player #(.NUM_VEC(5), .HOLD_W(4), .OUT_W(10)) u_dut (
        .clk(clk), .rst(rst), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_vec(tbl_wr_vec), .tbl_wr_hold(tbl_wr_hold), .tbl_wr_exp(tbl_wr_exp),
        .start(start), .abcd(abcd), .dut_resp(dut_resp), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_match(resp_match),
        .busy(busy), .done(done), .err_count(err_count)
    );

    // Empty 300-entry table against an all-ones response: every entry mismatches.
    gate_vector_player #(.NUM_VEC(300), .HOLD_W(4), .OUT_W(10)) u_big (
        .clk(clk), .rst(rst), .tbl_wr_en(1'b0), .tbl_wr_addr(9'd0),
        .tbl_wr_vec(4'd0), .tbl_wr_hold(4'd0), .tbl_wr_exp(10'd0),
        .start(start_b), .abcd(abcd_b), .dut_resp(10'h3FF), .resp_valid(valid_b),
        .resp_ready(1'b1), .resp_data(data_b), .resp_match(match_b),
        .busy(busy_b), .done(done_b), .err_count(err_b)
    );

    function automatic logic [9:0] gate(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return {a & b & c & d, ~d, c ^ d, c | d, c & d,
                a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    always_comb dut_resp = gate(abcd);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic prog(input int k, input logic [3:0] v, input logic [3:0] h, input logic [9:0] e);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 3'(k);
        tbl_wr_vec  = v;
        tbl_wr_hold = h;
        tbl_wr_exp  = e;
        @(negedge clk);
        tbl_wr_en   = 1'b0;
        m_vec[k]  = v;
        m_hold[k] = h;
        m_exp[k]  = e;
    endtask

    task automatic load_normal();
        m_resp[0] = 10'h1D6; m_resp[1] = 10'h0D6; m_resp[2] = 10'h1CC;
        m_resp[3] = 10'h263; m_resp[4] = 10'h10C;
        prog(0, 4'b1010, 4'd0, 10'h1D6);
        prog(1, 4'b0101, 4'd1, 10'h0D6);
        prog(2, 4'b0010, 4'd3, 10'h1CC);
        prog(3, 4'b1111, 4'd1, 10'h263);
        prog(4, 4'b0000, 4'd1, 10'h10C);
    endtask

    task automatic do_run(input int stall_beat, input bit disturb, input int exp_err);
        int cyc;
        int guard;
        start      = 1'b1;
        resp_ready = (stall_beat != 0);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc   = 0;
            guard = 0;
            while (!resp_valid && guard < 40) begin
                guard++;
                if (abcd == m_vec[k]) cyc++;
                if (disturb && k == 2 && cyc == 1) begin
                    start = 1'b1; tbl_wr_en = 1'b1; tbl_wr_addr = 3'd0;
                    tbl_wr_vec = 4'hF; tbl_wr_hold = 4'd0; tbl_wr_exp = 10'd0;
                end else begin
                    start = 1'b0; tbl_wr_en = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0; tbl_wr_en = 1'b0;
            chk("hold_len", cyc, 32'(m_hold[k]) + 1);
            chk("beat_data", resp_data, {m_vec[k], m_resp[k]});
            chk("beat_match", resp_match, 32'(m_exp[k] == m_resp[k]));
            chk("beat_abcd", abcd, m_vec[k]);
            if (k == stall_beat) begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", resp_valid, 1);
                    chk("stall_data", resp_data, {m_vec[k], m_resp[k]});
                    chk("stall_abcd", abcd, m_vec[k]);
                end
                resp_ready = 1'b1;
            end
            @(negedge clk);
            resp_ready = (k + 1 != stall_beat);
        end
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("valid_end", resp_valid, 0);
        chk("abcd_idle", abcd, 0);
        chk("err_final", err_count, exp_err);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("err_hold", err_count, exp_err);
    endtask

    initial begin
        int guard;
        rst = 1'b1; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_vec = '0;
        tbl_wr_hold = '0; tbl_wr_exp = '0; start = 1'b0; resp_ready = 1'b1; start_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_abcd", abcd, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_match", resp_match, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_count, 0);
        rst = 1'b0;
        @(negedge clk);

        load_normal();
        do_run(-1, 1'b0, 0);

        prog(2, 4'b0010, 4'd3, 10'h1CD);
        do_run(-1, 1'b0, 1);
        prog(2, 4'b0010, 4'd3, 10'h1CC);

        do_run(1, 1'b0, 0);
        do_run(-1, 1'b1, 0);
        do_run(-1, 1'b0, 0);

        start = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(abcd == 4'hF && !resp_valid) && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        chk("reach_v3", abcd, 4'hF);
        rst = 1'b1;
        #1;
        chk("mid_rst_abcd", abcd, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_data", resp_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", resp_valid, 0);

        // Cleared table: every entry is vector 0000, hold 0, expected 0.
        for (int k = 0; k < 5; k++) begin
            m_vec[k] = 4'd0; m_hold[k] = 4'd0; m_exp[k] = 10'd0; m_resp[k] = 10'h10C;
        end
        for (int r = 0; r < 61; r++) begin
            do_run(-1, 1'b0, 5);
        end

        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        guard = 0;
        while (!done_b && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        chk("big_done", done_b, 1);
        chk("big_err_sat", err_b, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
